// File: rtl/state_dispatch_queue.sv
// state_dispatch_queue: decodes accepted instructions to control-FSM entry states and queues them for the control unit.
// Optional feature macro STATE_DISPATCH_TRAP_EN: unknown instructions decode to TRAP_STATE and pulse o_trap.
module state_dispatch_queue #(
    parameter int STATE_W       = 7,
    parameter int DEPTH         = 2,
    parameter int DEFAULT_STATE = 1,
    parameter int TRAP_STATE    = 63
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [31:0]             i_instr_in,
    input  logic                    i_instr_valid,
    output logic                    o_instr_ready,
    input  logic                    i_flush,
    output logic [STATE_W-1:0]      o_state_sel,
    output logic [31:0]             o_state_instr,
    output logic                    o_state_valid,
    input  logic                    i_state_ack,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic [15:0]             o_unknown_cnt
`ifdef STATE_DISPATCH_TRAP_EN
    ,
    output logic                    o_trap
`endif
);
    localparam int AW = $clog2(DEPTH);
`ifdef STATE_DISPATCH_TRAP_EN
    localparam logic [STATE_W-1:0] UNK_STATE = STATE_W'(TRAP_STATE);
`else
    localparam logic [STATE_W-1:0] UNK_STATE = STATE_W'(DEFAULT_STATE);
`endif

    logic [5:0]         w_op, w_fn;
    logic [4:0]         w_rt;
    logic [6:0]         w_code;
    logic               w_dec_unk;
    logic [STATE_W-1:0] w_dec_state;

    assign w_op = i_instr_in[31:26];
    assign w_fn = i_instr_in[5:0];
    assign w_rt = i_instr_in[20:16];

    // w_code of zero marks an unrecognised instruction; every real state is non-zero
    always_comb begin
        w_code = '0;
        case (w_op)
            6'b000000: case (w_fn)
                6'b100001: w_code = 7'd6;
                6'b100011: w_code = 7'd17;
                6'b101011: w_code = 7'd19;
                6'b100100: w_code = 7'd23;
                6'b100101: w_code = 7'd25;
                6'b100110: w_code = 7'd27;
                6'b100111: w_code = 7'd29;
                6'b000000: w_code = 7'd31;
                6'b000011: w_code = 7'd32;
                6'b000010: w_code = 7'd33;
                6'b001011: w_code = 7'd34;
                6'b001010: w_code = 7'd35;
                6'b010000: w_code = 7'd45;
                6'b010010: w_code = 7'd46;
                6'b010001: w_code = 7'd47;
                6'b010011: w_code = 7'd48;
                6'b011001: w_code = (i_instr_in[15:6] == '0) ? 7'd49 : 7'd0;
                6'b001000: w_code = (i_instr_in[20:11] == '0) ? 7'd44 : 7'd0;
                default:   w_code = 7'd0;
            endcase
            6'b011100: w_code = (w_fn == 6'b100001) ? 7'd21 : (w_fn == 6'b100000) ? 7'd22 : 7'd0;
            6'b000001: w_code = (w_rt == 5'b00001) ? 7'd37 : (w_rt == 5'b10001) ? 7'd56 : 7'd0;
            6'b001001: w_code = 7'd18;
            6'b001011: w_code = 7'd20;
            6'b001100: w_code = 7'd24;
            6'b001101: w_code = 7'd26;
            6'b001110: w_code = 7'd28;
            6'b001111: w_code = 7'd30;
            6'b101000, 6'b101001, 6'b101011: w_code = 7'd7;
            6'b111111: w_code = 7'd50;
            6'b000100: w_code = 7'd11;
            6'b000101: w_code = 7'd41;
            6'b000111: w_code = (w_rt == '0) ? 7'd39 : 7'd0;
            6'b000110: w_code = (w_rt == '0) ? 7'd42 : 7'd0;
            6'b100011, 6'b100001, 6'b100101, 6'b100000, 6'b100100: w_code = 7'd13;
            default: w_code = 7'd0;
        endcase
    end

    assign w_dec_unk   = (w_code == '0);
    assign w_dec_state = w_dec_unk ? UNK_STATE : STATE_W'(w_code);

    logic [STATE_W-1:0] r_mem_state [DEPTH];
    logic [31:0]        r_mem_instr [DEPTH];
    logic [AW-1:0]      r_wr, r_rd, w_rd_nxt;
    logic [AW:0]        r_count, w_count_nxt;
    logic               r_valid;
    logic [STATE_W-1:0] r_sel;
    logic [31:0]        r_instr;
    logic [15:0]        r_unk_cnt;
    logic               w_push, w_pop, w_bypass;

    assign o_instr_ready = (r_count != (AW+1)'(DEPTH));
    assign w_push        = i_instr_valid && o_instr_ready && !i_flush;
    assign w_pop         = r_valid && i_state_ack && !i_flush;
    assign w_rd_nxt      = r_rd + AW'(w_pop);
    assign w_count_nxt   = i_flush ? '0 : r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    // Queue drains to nothing but the incoming entry: head comes straight from the decoder
    assign w_bypass      = ((r_count - (AW+1)'(w_pop)) == '0);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_state[r_wr] <= w_dec_state;
            r_mem_instr[r_wr] <= i_instr_in;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr      <= '0;
            r_rd      <= '0;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_sel     <= '0;
            r_instr   <= '0;
            r_unk_cnt <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
            if (i_flush) begin
                r_rd <= r_wr;
            end else begin
                r_wr <= r_wr + AW'(w_push);
                r_rd <= w_rd_nxt;
            end
            if (w_count_nxt != '0) begin
                r_sel   <= w_bypass ? w_dec_state : r_mem_state[w_rd_nxt];
                r_instr <= w_bypass ? i_instr_in : r_mem_instr[w_rd_nxt];
            end
            if (w_push && w_dec_unk && r_unk_cnt != 16'hFFFF)
                r_unk_cnt <= r_unk_cnt + 16'd1;
        end
    end

`ifdef STATE_DISPATCH_TRAP_EN
    logic r_trap;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_trap <= 1'b0;
        else         r_trap <= w_push && w_dec_unk;
    end
    assign o_trap = r_trap;
`endif

    assign o_count       = r_count;
    assign o_state_valid = r_valid;
    assign o_state_sel   = r_sel;
    assign o_state_instr = r_instr;
    assign o_unknown_cnt = r_unk_cnt;
endmodule

// File: tb/tb_state_dispatch_queue.sv
// tb_state_dispatch_queue: directed and random stimulus against a rule-table queue model of state_dispatch_queue.
module tb_state_dispatch_queue;
    localparam int DEPTH = 2;
`ifdef STATE_DISPATCH_TRAP_EN
    localparam int UNK = 63;
`else
    localparam int UNK = 1;
`endif
    localparam logic [31:0] FNM = 32'hFC00003F, OPM = 32'hFC000000, RTM = 32'hFC1F0000;

    logic        i_clk = 1'b0, i_reset = 1'b1;
    logic [31:0] i_instr_in = '0;
    logic        i_instr_valid = 1'b0, i_flush = 1'b0, i_state_ack = 1'b0;
    logic        o_instr_ready, o_state_valid;
    logic [6:0]  o_state_sel;
    logic [31:0] o_state_instr;
    logic [1:0]  o_count;
    logic [15:0] o_unknown_cnt;
`ifdef STATE_DISPATCH_TRAP_EN
    logic        o_trap;
`endif

    state_dispatch_queue #(.STATE_W(7), .DEPTH(DEPTH), .DEFAULT_STATE(1), .TRAP_STATE(63)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_instr_in(i_instr_in), .i_instr_valid(i_instr_valid),
        .o_instr_ready(o_instr_ready), .i_flush(i_flush), .o_state_sel(o_state_sel),
        .o_state_instr(o_state_instr), .o_state_valid(o_state_valid), .i_state_ack(i_state_ack),
        .o_count(o_count), .o_unknown_cnt(o_unknown_cnt)
`ifdef STATE_DISPATCH_TRAP_EN
        , .o_trap(o_trap)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed { logic [31:0] m; logic [31:0] v; logic [7:0] s; } rule_t;
    typedef struct packed { logic [6:0] sel; logic [31:0] ins; } ent_t;
    rule_t       rules[$];
    ent_t        mq[$];
    logic [6:0]  m_sel = '0;
    logic [31:0] m_instr = '0;
    logic [15:0] m_unk = '0;
    logic        m_trap = 1'b0;
    bit          quiet = 1'b0;
    int          n_chk = 0, n_err = 0;

    function automatic logic [31:0] op(input logic [5:0] o);
        return {o, 26'h0};
    endfunction

    function automatic void add(input logic [31:0] m, input logic [31:0] v, input int s);
        rules.push_back('{m: m, v: v, s: 8'(s)});
    endfunction

    function automatic int ref_decode(input logic [31:0] x);
        foreach (rules[k]) if ((x & rules[k].m) == rules[k].v) return int'(rules[k].s);
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [31:0] ins, input logic ack, input logic fl);
        int  s;
        bit  push, pop;
        i_instr_valid = v; i_instr_in = ins; i_state_ack = ack; i_flush = fl;
        @(posedge i_clk);
        push = v && mq.size() < DEPTH && !fl;
        pop  = mq.size() > 0 && ack && !fl;
        s    = ref_decode(ins);
        if (fl) mq.delete();
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (s == 0 && m_unk != 16'hFFFF) m_unk++;
            mq.push_back('{sel: 7'(s == 0 ? UNK : s), ins: ins});
        end
        m_trap = push && s == 0;
        if (mq.size() > 0) begin m_sel = mq[0].sel; m_instr = mq[0].ins; end
        #1;
        if (!quiet) begin
            chk("count", 32'(o_count), 32'(mq.size()));
            chk("ready", 32'(o_instr_ready), 32'(mq.size() != DEPTH));
            chk("valid", 32'(o_state_valid), 32'(mq.size() != 0));
            chk("sel", 32'(o_state_sel), 32'(m_sel));
            chk("instr", o_state_instr, m_instr);
            chk("unknown_cnt", 32'(o_unknown_cnt), 32'(m_unk));
`ifdef STATE_DISPATCH_TRAP_EN
            chk("trap", 32'(o_trap), 32'(m_trap));
`endif
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_count"}, 32'(o_count), 0);
        chk({tag, "_valid"}, 32'(o_state_valid), 0);
        chk({tag, "_sel"}, 32'(o_state_sel), 0);
        chk({tag, "_instr"}, o_state_instr, 0);
        chk({tag, "_unk"}, 32'(o_unknown_cnt), 0);
`ifdef STATE_DISPATCH_TRAP_EN
        chk({tag, "_trap"}, 32'(o_trap), 0);
`endif
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 3))
            0: return r;
            1: return {6'b000000, r[25:11], 5'b0, r[5:0]};
            2: return {($urandom_range(0, 1) ? 6'b011100 : 6'b000001), r[25:0]};
            default: return {r[31:26], 5'b0, r[20:16] & {5{r[0]}}, r[15:0]};
        endcase
    endfunction

    initial begin
        int sp_fn[18] = '{'h21, 'h23, 'h2B, 'h24, 'h25, 'h26, 'h27, 'h00, 'h03, 'h02, 'h0B, 'h0A, 'h10, 'h12, 'h11, 'h13, -1, -1};
        int sp_st[16] = '{6, 17, 19, 23, 25, 27, 29, 31, 32, 33, 34, 35, 45, 46, 47, 48};
        for (int k = 0; k < 16; k++) add(FNM, 32'(sp_fn[k]), sp_st[k]);
        add(32'hFC00FFFF, 32'h00000019, 49);
        add(32'hFC1FF83F, 32'h00000008, 44);
        add(FNM, 32'h70000021, 21); add(FNM, 32'h70000020, 22);
        add(RTM, 32'h04010000, 37); add(RTM, 32'h04110000, 56);
        add(OPM, op(6'b001001), 18); add(OPM, op(6'b001011), 20); add(OPM, op(6'b001100), 24);
        add(OPM, op(6'b001101), 26); add(OPM, op(6'b001110), 28); add(OPM, op(6'b001111), 30);
        add(OPM, op(6'b101000), 7);  add(OPM, op(6'b101001), 7);  add(OPM, op(6'b101011), 7);
        add(OPM, op(6'b111111), 50); add(OPM, op(6'b000100), 11); add(OPM, op(6'b000101), 41);
        add(RTM, op(6'b000111), 39); add(RTM, op(6'b000110), 42);
        add(OPM, op(6'b100011), 13); add(OPM, op(6'b100001), 13); add(OPM, op(6'b100101), 13);
        add(OPM, op(6'b100000), 13); add(OPM, op(6'b100100), 13);

        #12 chk_zero("reset");
        #1 i_reset = 1'b0;
        @(negedge i_clk);

        cyc(1, 32'h00851021, 0, 0);
        chk("addu_sel", 32'(o_state_sel), 6);
        chk("addu_valid", 32'(o_state_valid), 1);
        cyc(0, 0, 1, 0);
        chk("addu_popped", 32'(o_state_valid), 0);

        cyc(1, 32'h8C880004, 0, 0);
        cyc(1, 32'hAC880004, 0, 0);
        chk("full_ready", 32'(o_instr_ready), 0);
        cyc(1, 32'h04A10003, 0, 0);
        chk("full_head", 32'(o_state_sel), 13);
        cyc(0, 0, 1, 0);
        chk("second_head", 32'(o_state_sel), 7);
        chk("ready_after_pop", 32'(o_instr_ready), 1);
        cyc(0, 0, 1, 0);
        chk("drained", 32'(o_state_valid), 0);

        cyc(1, 32'h24A50001, 0, 0);
        for (int k = 0; k < 5; k++) cyc(1, 32'h24A50001, 1, 0);
        chk("stream_count", 32'(o_count), 1);
        chk("stream_sel", 32'(o_state_sel), 18);
        cyc(0, 0, 1, 0);

        cyc(1, 32'hFC000000, 0, 0);
        cyc(1, 32'h7C000000, 1, 0);
        chk("sd_then_unk_sel", 32'(o_state_sel), 32'(UNK));
        chk("unk_cnt_one", 32'(o_unknown_cnt), 1);
        cyc(0, 0, 1, 0);

        cyc(1, 32'h8C880004, 0, 0);
        cyc(1, 32'hAC880004, 0, 0);
        cyc(1, 32'h7C000000, 1, 1);
        chk("flush_count", 32'(o_count), 0);
        chk("flush_valid", 32'(o_state_valid), 0);
        chk("flush_unk", 32'(o_unknown_cnt), 1);
        cyc(1, 32'h00851021, 0, 0);

        for (int k = 0; k < 400; k++)
            cyc(1'($urandom_range(0, 1)), rnd_instr(), 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);

        quiet = 1'b1;
        while (m_unk < 16'hFFFD) cyc(1, 32'h7C000000, 1, 0);
        quiet = 1'b0;
        for (int k = 0; k < 4; k++) cyc(1, 32'h7C000000, 1, 0);
        chk("unk_saturated", 32'(o_unknown_cnt), 32'hFFFF);

        cyc(1, 32'h8C880004, 0, 0);
        cyc(1, 32'h00851021, 0, 0);
        #3 i_reset = 1'b1;
        #1 chk_zero("async_reset");
        mq.delete(); m_sel = '0; m_instr = '0; m_unk = '0; m_trap = 1'b0;
        @(posedge i_clk); #1 chk_zero("held_reset");
        i_reset = 1'b0;
        cyc(1, 32'h8C880004, 0, 0);
        chk("post_reset_sel", 32'(o_state_sel), 13);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/state_dispatch_queue.md
Name: state_dispatch_queue

Overview:
- Parametrised, buffered successor to the combinational instruction-to-state encoder used by the multicycle control unit.
- Accepts fetched instructions over a valid/ready handshake and decodes each to a control-FSM entry state when it is accepted.
- Queues decoded entries in a DEPTH-deep FIFO and presents the head to the control unit, which consumes it with an acknowledge.
- Adds a flush for redirects and a saturating count of unknown instructions.

Parameters:
- STATE_W, 7, width of state select.
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- DEFAULT_STATE, 1, state for unrecognised instructions.
- TRAP_STATE, 63, state for unrecognised instructions when the trap feature is compiled in.

Ports:
- clk, input, 1, sole clock; rising edge.
- reset, input, 1, asynchronous, active-high.
- instr_in, input, 32, instruction word.
- instr_valid, input, 1, instr_in is valid.
- instr_ready, output, 1, queue can accept.
- flush, input, 1, synchronous discard of all queued entries.
- state_sel, output, STATE_W, decoded state at the queue head.
- state_instr, output, 32, instruction at the queue head.
- state_valid, output, 1, head entry is valid.
- state_ack, input, 1, control unit consumes the head.
- count, output, clog2(DEPTH)+1, occupancy.
- unknown_cnt, output, 16, saturating count of unknown instructions accepted.
- trap, output, 1, present only with the trap feature compiled in.

Behaviour:
- Reset (asynchronous, active-high): empty queue, pointers 0, count=0, state_valid=0, state_sel=0, state_instr=0, unknown_cnt=0, trap=0.
- Accept: instr_valid && instr_ready at a rising edge. instr_ready = (count != DEPTH); it is not a function of state_ack, so there is no combinational path from state_ack to instr_ready.
- Decode happens at accept time. First matching rule wins.
  - SPECIAL (op 000000), by funct:
    - 100001 -> 6; 100011 -> 17; 101011 -> 19.
    - 100100 -> 23; 100101 -> 25; 100110 -> 27; 100111 -> 29.
    - 000000 -> 31; 000011 -> 32; 000010 -> 33.
    - 001011 -> 34; 001010 -> 35.
    - 010000 -> 45; 010010 -> 46; 010001 -> 47; 010011 -> 48.
    - 011001 with [15:6]=0 -> 49.
    - 001000 with [20:11]=0 -> 44.
  - SPECIAL2 (op 011100): funct 100001 -> 21; funct 100000 -> 22.
  - REGIMM (op 000001): rt 00001 -> 37; rt 10001 -> 56.
  - Other opcodes:
    - 001001 -> 18; 001011 -> 20; 001100 -> 24; 001101 -> 26; 001110 -> 28; 001111 -> 30.
    - 101000, 101001, 101011 -> 7; 111111 -> 50.
    - 000100 -> 11; 000101 -> 41.
    - 000111 with rt=0 -> 39; 000110 with rt=0 -> 42.
    - 100011, 100001, 100101, 100000, 100100 -> 13.
  - Anything else -> DEFAULT_STATE, and unknown_cnt increments at accept, saturating at 16'hFFFF.
- Latency: an accept into an empty queue gives state_valid=1 on the following cycle.
- Outputs are driven from registers or the storage array only; no combinational path from instr_in.
- Pop: state_valid && state_ack. state_ack while empty is ignored.
- Simultaneous push and pop while not full: count is unchanged and both pointers advance.
- Full: instr_ready=0. A pop frees a slot, so instr_ready=1 on the next cycle.
- Pointers wrap modulo DEPTH.
- flush: at the next edge count=0, state_valid=0, and pointers are equalised.
  - A push or pop in the same cycle as flush is discarded.
  - unknown_cnt is not cleared, and an instruction dropped by flush is not counted.
- state_sel and state_instr hold their value while state_valid=0.
- Asserting reset mid-operation clears everything immediately, including a partially filled queue.

Optional Feature:
- Macro: STATE_DISPATCH_TRAP_EN.
- Defined:
  - Unknown instructions decode to TRAP_STATE.
  - The trap port exists and pulses high for one cycle, registered, on each unknown accept.
  - unknown_cnt still increments.
- Undefined: unknown instructions decode to DEFAULT_STATE, and the trap port is absent.

Test Plan:
- Reset, then push 32'h00851021 (ADDU) with the queue empty -> next cycle state_valid=1, state_sel=6, state_instr=32'h00851021; ack -> state_valid=0.
- DEPTH=2: push LW 32'h8C880004, SW 32'hAC880004 and BGEZ 32'h04A10003 with no ack -> instr_ready=0 after two pushes and the third is not accepted; ack twice -> heads 13 then 7.
- Queue holding one entry, push 32'h24A50001 and ack in the same cycle -> count stays 1, head becomes state 18; pointers wrap correctly after 5 such cycles.
- Push 32'hFC000000 (SD) then 32'h7C000000 (unknown) -> states 50 then 1 (63 with macro, trap pulse of one cycle); unknown_cnt=1.
- Queue full, assert flush together with instr_valid and state_ack -> next cycle count=0, state_valid=0, nothing popped or pushed, unknown_cnt unchanged.
- Force unknown_cnt to 16'hFFFF, push one unknown -> it stays 16'hFFFF. Assert reset mid-burst -> all outputs zero asynchronously.
